// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length header plus N big-endian 32-bit words from a byte
// stream, writes them into imem through the boot port, then releases the CPU.
module imem_boot_loader #(
    parameter int I_ADDRESSWIDTH = 8,
    parameter int I_SIZE         = 64,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT        = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  boot_iaddr,
    output logic [31:0] boot_idata,
    output logic        boot_iwe,
    output logic        cpu_resetn,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LOAD, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'(I_SIZE - BASE_ADDR);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

    state_t                    state;
    logic [1:0]                byte_cnt;
    logic [23:0]               shreg;
    logic [31:0]               remaining;
    logic [31:0]               tcnt;
    logic [I_ADDRESSWIDTH-1:0] addr;

    logic        accept;
    logic [31:0] shifted;
    logic        timed_out;

    // Handshake: a byte moves only on a cycle where in_valid and in_ready are both high.
    assign accept    = in_valid & in_ready;
    assign shifted   = {shreg, in_data};
    assign timed_out = (TIMEOUT != 0) && !accept && (tcnt == TO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            boot_iwe   <= 1'b0;
            boot_iaddr <= 8'd0;
            boot_idata <= 32'd0;
            cpu_resetn <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            byte_cnt   <= 2'd0;
            shreg      <= 24'd0;
            remaining  <= 32'd0;
            tcnt       <= 32'd0;
            addr       <= '0;
        end else begin
            boot_iwe <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_HDR;
                        in_ready   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        cpu_resetn <= 1'b0;
                        byte_cnt   <= 2'd0;
                        tcnt       <= 32'd0;
                    end
                end
                S_HDR, S_LOAD: begin
                    if (accept) begin
                        shreg    <= shifted[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        tcnt     <= 32'd0;
                        if (byte_cnt == 2'd3) begin
                            if (state == S_HDR) begin
                                if (shifted == 32'd0) begin
                                    state      <= S_DONE;
                                    in_ready   <= 1'b0;
                                    done       <= 1'b1;
                                    cpu_resetn <= 1'b1;
                                end else if (shifted > MAX_WORDS) begin
                                    state    <= S_ERR;
                                    in_ready <= 1'b0;
                                    err      <= 1'b1;
                                end else begin
                                    state     <= S_LOAD;
                                    addr      <= I_ADDRESSWIDTH'(BASE_ADDR);
                                    remaining <= shifted;
                                end
                            end else begin
                                state      <= S_WRITE;
                                in_ready   <= 1'b0;
                                boot_iwe   <= 1'b1;
                                boot_iaddr <= 8'(addr);
                                boot_idata <= shifted;
                            end
                        end
                    end else if (timed_out) begin
                        state    <= S_ERR;
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                        tcnt     <= 32'd0;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                S_WRITE: begin
                    addr      <= addr + I_ADDRESSWIDTH'(1);
                    remaining <= remaining - 32'd1;
                    if (remaining == 32'd1) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        cpu_resetn <= 1'b1;
                    end else begin
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
